// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with double-buffered digits, per-digit blank/blink and frame tick.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int NDIG         = 4,
    parameter int SCAN_CNT     = 100000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NDIG-1:0]   hexs,
    input  logic [NDIG-1:0]     points,
    input  logic [NDIG-1:0]     les,
    input  logic [NDIG-1:0]     blink,
    input  logic                load,
    output logic                pend,
    output logic                frame_tick,
    output logic [NDIG-1:0]     AN,
    output logic [7:0]          SEGMENT
);

    localparam int PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_CNT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]      r_presc;
    logic [IW-1:0]      r_idx;
    logic [4*NDIG-1:0]  r_pend_hex;
    logic [NDIG-1:0]    r_pend_pts;
    logic [NDIG-1:0]    r_pend_les;
    logic [NDIG-1:0]    r_pend_blk;
    logic [4*NDIG-1:0]  r_disp_hex;
    logic [NDIG-1:0]    r_disp_pts;
    logic [NDIG-1:0]    r_disp_les;
    logic [NDIG-1:0]    r_disp_blk;
    logic               r_pend;
    logic               r_phase;
    logic [BW-1:0]      r_bcnt;
    logic               r_frame_tick;
    logic [NDIG-1:0]    r_an;
    logic [7:0]         r_seg;

    logic               w_tick;
    logic               w_wrap;
    logic [3:0]         w_hex;
    logic               w_pt;
    logic               w_le;
    logic               w_bl;
    logic               w_lz;
    logic               w_blank;
    logic [NDIG-1:0]    w_lzb;

    // Pin-level (active-low) g..a pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic v_zero;
        w_lzb  = '0;
        v_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            v_zero   = v_zero & (r_disp_hex[4*i +: 4] == 4'h0);
            w_lzb[i] = v_zero;
        end
    end
`else
    assign w_lzb = '0;
`endif

    always_comb begin
        w_hex = 4'h0;
        w_pt  = 1'b0;
        w_le  = 1'b0;
        w_bl  = 1'b0;
        w_lz  = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_hex = r_disp_hex[4*i +: 4];
                w_pt  = r_disp_pts[i];
                w_le  = r_disp_les[i];
                w_bl  = r_disp_blk[i];
                w_lz  = w_lzb[i];
            end
        end
    end

    assign w_blank = w_le | (w_bl & r_phase) | w_lz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend_hex   <= '0;
            r_pend_pts   <= '0;
            r_pend_les   <= '0;
            r_pend_blk   <= '0;
            r_disp_hex   <= '0;
            r_disp_pts   <= '0;
            r_disp_les   <= '0;
            r_disp_blk   <= '0;
            r_pend       <= 1'b0;
            r_phase      <= 1'b0;
            r_bcnt       <= '0;
            r_frame_tick <= 1'b0;
            r_an         <= '1;
            r_seg        <= 8'hFF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_frame_tick <= w_wrap;

            // Commit takes the pending buffer as it stood before any same-cycle load.
            if (w_wrap) begin
                if (r_pend) begin
                    r_disp_hex <= r_pend_hex;
                    r_disp_pts <= r_pend_pts;
                    r_disp_les <= r_pend_les;
                    r_disp_blk <= r_pend_blk;
                end
                if (r_bcnt == BLINK_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end

            if (load) begin
                r_pend_hex <= hexs;
                r_pend_pts <= points;
                r_pend_les <= les;
                r_pend_blk <= blink;
                r_pend     <= 1'b1;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end

            r_an  <= ~(NDIG'(1) << r_idx);
            r_seg <= w_blank ? 8'hFF : {~w_pt, seg_decode(w_hex)};
        end
    end

    assign pend       = r_pend;
    assign frame_tick = r_frame_tick;
    assign AN         = r_an;
    assign SEGMENT    = r_seg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table of digit patterns through a scoreboard queue, plus hand sequences.
// A second instance (NDIG=8, SCAN_CNT=1) covers single-cycle slots and mid-frame reset.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic [3:0]  blink;
    logic        load;
    logic        pend;
    logic        frame_tick;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    logic        rst2;
    logic [31:0] hexs2;
    logic [7:0]  points2;
    logic [7:0]  les2;
    logic [7:0]  blink2;
    logic        load2;
    logic        pend2;
    logic        ft2;
    logic [7:0]  an2;
    logic [7:0]  seg2;

    seg_scan_ctrl #(.NDIG(4), .SCAN_CNT(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .les(les), .blink(blink),
        .load(load), .pend(pend), .frame_tick(frame_tick), .AN(AN), .SEGMENT(SEGMENT)
    );

    seg_scan_ctrl #(.NDIG(8), .SCAN_CNT(1), .BLINK_FRAMES(32)) dut2 (
        .clk(clk), .rst(rst2), .hexs(hexs2), .points(points2), .les(les2), .blink(blink2),
        .load(load2), .pend(pend2), .frame_tick(ft2), .AN(an2), .SEGMENT(seg2)
    );

    typedef struct packed {
        logic [15:0] hexs;
        logic [3:0]  points;
        logic [3:0]  les;
        logic [3:0]  blink;
        logic [31:0] seg;   // expected SEGMENT per digit, digit d in [8d+7:8d], no blink/LZB applied
    } vec_t;

    vec_t tbl [7];
    vec_t sbq [$];
    int   checks   = 0;
    int   failures = 0;
    int   wraps;

    always @(posedge clk) begin
        if (rst) wraps <= 0;
        else if (frame_tick) wraps <= wraps + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_lzb(input vec_t v);
        logic [31:0] s;
        logic        zero;
        s    = v.seg;
        zero = 1'b1;
`ifdef SEG_SCAN_LZB_EN
        for (int d = 3; d >= 1; d--) begin
            zero = zero & (v.hexs[4*d +: 4] == 4'h0);
            if (zero) s[8*d +: 8] = 8'hFF;
        end
`endif
        return s;
    endfunction

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 64);
        if (!frame_tick) begin
            checks++;
            failures++;
            $display("FAIL %s: no frame_tick within 64 cycles", name);
        end
    endtask

    task automatic load_vec(input vec_t v, input bit push);
        hexs   = v.hexs;
        points = v.points;
        les    = v.les;
        blink  = v.blink;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        if (push) sbq.push_back(v);
    endtask

    // Called at the negedge where frame_tick is high; checks the four slots of the next frame.
    task automatic observe(input string name);
        vec_t        e;
        logic [31:0] segs;
        logic [7:0]  exp_seg;
        logic [3:0]  exp_an;
        int          ph;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e    = sbq.pop_front();
        segs = apply_lzb(e);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            ph      = (wraps / 2) % 2;
            exp_an  = ~(4'd1 << d);
            exp_seg = segs[8*d +: 8];
            if (e.blink[d] && ph == 1) exp_seg = 8'hFF;
            chk($sformatf("%s AN d%0d", name, d), {28'd0, AN}, {28'd0, exp_an});
            chk($sformatf("%s SEG d%0d", name, d), {24'd0, SEGMENT}, {24'd0, exp_seg});
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       v;
        vec_t       zero_v;
        logic [7:0] exp8;

        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 4'b0000, 32'hF9A4B099};
        tbl[1] = '{16'h5555, 4'b0000, 4'b0000, 4'b0000, 32'h92929292};
        tbl[2] = '{16'h0070, 4'b0000, 4'b0000, 4'b0000, 32'hC0C0F8C0};
        tbl[3] = '{16'h89AB, 4'b0101, 4'b0000, 4'b0000, 32'h80108803};
        tbl[4] = '{16'hCDEF, 4'b0000, 4'b0010, 4'b0000, 32'hC6A1FF8E};
        tbl[5] = '{16'h6000, 4'b1000, 4'b0000, 4'b0000, 32'h02C0C0C0};
        tbl[6] = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 32'hC0C0C0C0};
        zero_v = tbl[6];

        rst = 1'b1; load = 1'b0; hexs = '0; points = '0; les = '0; blink = '0;
        rst2 = 1'b1; load2 = 1'b0; hexs2 = '0; points2 = '0; les2 = '0; blink2 = '0;

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst AN", {28'd0, AN}, 32'hF);
            chk("rst SEG", {24'd0, SEGMENT}, 32'hFF);
            chk("rst pend", {31'd0, pend}, 32'd0);
            chk("rst frame_tick", {31'd0, frame_tick}, 32'd0);
            chk("rst2 AN", {24'd0, an2}, 32'hFF);
            chk("rst2 SEG", {24'd0, seg2}, 32'hFF);
        end

        rst = 1'b0;
        @(negedge clk);
        chk("first slot AN", {28'd0, AN}, 32'hE);
        chk("first slot SEG", {24'd0, SEGMENT}, 32'hC0);

        for (int i = 0; i < 7; i++) begin
            wait_frame($sformatf("vec%0d sync", i));
            load_vec(tbl[i], 1'b1);
            chk($sformatf("vec%0d pend set", i), {31'd0, pend}, 32'd1);
            wait_frame($sformatf("vec%0d commit", i));
            chk($sformatf("vec%0d pend clr", i), {31'd0, pend}, 32'd0);
            observe($sformatf("vec%0d", i));
        end

        // Two loads in one frame: last wins
        wait_frame("ovr sync");
        v = tbl[0]; v.hexs = 16'hAAAA;
        load_vec(v, 1'b0);
        @(negedge clk);
        load_vec(tbl[1], 1'b1);
        wait_frame("ovr commit");
        observe("ovr");

        // Load on the wrap cycle itself: old pending commits, new data waits a frame
        wait_frame("coin sync");
        load_vec(tbl[0], 1'b1);
        repeat (6) @(negedge clk);
        hexs = tbl[3].hexs; points = tbl[3].points; les = tbl[3].les; blink = tbl[3].blink;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sbq.push_back(tbl[3]);
        chk("coin frame_tick", {31'd0, frame_tick}, 32'd1);
        chk("coin pend held", {31'd0, pend}, 32'd1);
        observe("coin old");
        chk("coin frame_tick2", {31'd0, frame_tick}, 32'd1);
        chk("coin pend clr", {31'd0, pend}, 32'd0);
        observe("coin new");

        // Blink digit 0 across four frames (phase flips every two frames)
        v = tbl[0]; v.blink = 4'b0001;
        wait_frame("blink sync");
        load_vec(v, 1'b1);
        sbq.push_back(v);
        sbq.push_back(v);
        sbq.push_back(v);
        wait_frame("blink commit");
        for (int f = 0; f < 4; f++) observe($sformatf("blink f%0d", f));

        // Reset mid-frame with data pending: pending is discarded
        wait_frame("mrst sync");
        load_vec(tbl[1], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst AN", {28'd0, AN}, 32'hF);
        chk("mrst SEG", {24'd0, SEGMENT}, 32'hFF);
        chk("mrst pend", {31'd0, pend}, 32'd0);
        chk("mrst frame_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        sbq.push_back(zero_v);
        wait_frame("mrst frame");
        observe("mrst blank");

        // Eight digits, one cycle per slot
        rst2 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp8 = ~(8'd1 << ((k - 1) % 8));
            chk($sformatf("n8 ft k%0d", k), {31'd0, ft2}, {31'd0, (k % 8 == 0)});
            chk($sformatf("n8 AN k%0d", k), {24'd0, an2}, {24'd0, exp8});
        end
        repeat (5) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        chk("n8 mrst AN", {24'd0, an2}, 32'hFF);
        chk("n8 mrst SEG", {24'd0, seg2}, 32'hFF);
        chk("n8 mrst ft", {31'd0, ft2}, 32'd0);
        rst2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp8 = ~(8'd1 << ((k - 1) % 8));
            chk($sformatf("n8 post ft k%0d", k), {31'd0, ft2}, {31'd0, (k % 8 == 0)});
            chk($sformatf("n8 post AN k%0d", k), {24'd0, an2}, {24'd0, exp8});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
